// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between two requesters.
// Round-robin arbitration, registered memory command, read-latency wait,
// and a one-cycle ack (plus read data) back to the winner.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: requester 0 always wins
// contention and the round-robin pointer is removed.
module mem_port_arbiter #(
  parameter int AW     = 6,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam int CW = 2;

  state_t        state_r,     state_n;
  logic          mem_en_r,    mem_en_n;
  logic          mem_wr_r,    mem_wr_n;
  logic [AW-1:0] mem_addr_r,  mem_addr_n;
  logic [DW-1:0] mem_wdata_r, mem_wdata_n;
  logic [DW-1:0] rdata_r,     rdata_n;
  logic          ack0_r,      ack0_n;
  logic          ack1_r,      ack1_n;
  logic          gnt_r,       gnt_n;
  logic [CW-1:0] cnt_r,       cnt_n;

  logic          elig0_s;
  logic          elig1_s;
  logic          grant1_s;

  // A requester currently being acked is not eligible, so a held req is
  // not re-granted in its own ack cycle.
  assign elig0_s = req0 & ~ack0_r;
  assign elig1_s = req1 & ~ack1_r;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign grant1_s = elig1_s & ~elig0_s;
`else
  logic rr_r, rr_n;
  // rr_r = 0 favours requester 0, 1 favours requester 1.
  assign grant1_s = elig1_s & (~elig0_s | rr_r);
`endif

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_n     = state_r;
    mem_en_n    = 1'b0;
    mem_wr_n    = 1'b0;
    mem_addr_n  = mem_addr_r;
    mem_wdata_n = mem_wdata_r;
    rdata_n     = rdata_r;
    ack0_n      = 1'b0;
    ack1_n      = 1'b0;
    gnt_n       = gnt_r;
    cnt_n       = cnt_r;
`ifndef MEM_ARB_FIXED_PRIO_EN
    rr_n        = rr_r;
`endif
    case (state_r)
      IDLE: begin
        if (elig0_s || elig1_s) begin
          gnt_n       = grant1_s;
          mem_en_n    = 1'b1;
          mem_wr_n    = grant1_s ? wr1    : wr0;
          mem_addr_n  = grant1_s ? addr1  : addr0;
          mem_wdata_n = grant1_s ? wdata1 : wdata0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          rr_n        = ~grant1_s;
`endif
          state_n     = ACCESS;
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        if (mem_wr_r) begin
          ack0_n  = ~gnt_r;
          ack1_n  = gnt_r;
          state_n = IDLE;
        end else begin
          cnt_n   = CW'(RD_LAT - 1);
          state_n = RDWAIT;
        end
      end
      RDWAIT: begin
        if (cnt_r == {CW{1'b0}}) begin
          rdata_n = mem_rdata;
          ack0_n  = ~gnt_r;
          ack1_n  = gnt_r;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mem_en_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      rdata_r     <= {DW{1'b0}};
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      gnt_r       <= 1'b0;
      cnt_r       <= {CW{1'b0}};
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_r        <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      mem_en_r    <= mem_en_n;
      mem_wr_r    <= mem_wr_n;
      mem_addr_r  <= mem_addr_n;
      mem_wdata_r <= mem_wdata_n;
      rdata_r     <= rdata_n;
      ack0_r      <= ack0_n;
      ack1_r      <= ack1_n;
      gnt_r       <= gnt_n;
      cnt_r       <= cnt_n;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_r        <= rr_n;
`endif
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_wr    = mem_wr_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rdata     = rdata_r;
  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// commands and acks into queues; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, wr0, ack0;
  logic [5:0] addr0;
  logic [7:0] wdata0;
  logic       req1, wr1, ack1;
  logic [5:0] addr1;
  logic [7:0] wdata1;
  logic [7:0] rdata;
  logic       mem_en, mem_wr;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef struct {
    logic       idx;
    logic       rd;
    logic [7:0] rdata;
  } ack_t;

  cmd_t cmd_q[$];
  ack_t ack_q[$];

  logic [7:0] mem [64];

  mem_port_arbiter #(.AW(6), .DW(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, preloaded while reset is high.
  always @(posedge clk) begin
    if (rst) begin
      mem[23] <= 8'h3C;
      mem[48] <= 8'h77;
      mem[56] <= 8'h99;
    end else if (mem_en && mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end else if (mem_en && !mem_wr) begin
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic wr, input logic [5:0] addr, input logic [7:0] wdata);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata;
    cmd_q.push_back(c);
  endtask

  task automatic push_ack(input logic idx, input logic rd, input logic [7:0] rd_val);
    ack_t a;
    a.idx = idx; a.rd = rd; a.rdata = rd_val;
    ack_q.push_back(a);
  endtask

  task automatic wait_ack(input logic idx, input int max_cyc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if ((idx ? ack1 : ack0) == 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait_ack_timeout", 32'(got), 32'd1);
  endtask

  // Monitor: compares every memory command and every ack against the queues.
  always @(negedge clk) begin
    cmd_t c;
    ack_t a;
    if (mem_en === 1'b1) begin
      if (cmd_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_mem_en: got addr 0x%0h expected no command", mem_addr);
      end else begin
        c = cmd_q.pop_front();
        chk("cmd_wr", 32'(mem_wr), 32'(c.wr));
        chk("cmd_addr", 32'(mem_addr), 32'(c.addr));
        if (c.wr) chk("cmd_wdata", 32'(mem_wdata), 32'(c.wdata));
      end
    end
    if (ack0 === 1'b1 || ack1 === 1'b1) begin
      chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
      if (ack_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none", ack0, ack1);
      end else begin
        a = ack_q.pop_front();
        chk("ack_idx", 32'(ack1), 32'(a.idx));
        if (a.rd) chk("ack_rdata", 32'(rdata), 32'(a.rdata));
      end
    end
  end

  initial begin
    int n_ack;
    rst = 1'b1;
    req0 = 1'b0; wr0 = 1'b0; addr0 = 6'd0; wdata0 = 8'd0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = 6'd0; wdata1 = 8'd0;
    tick();
    tick();
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_ack", 32'({ack0, ack1}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;

    // Single write from requester 0.
    req0 = 1'b1; wr0 = 1'b1; addr0 = 6'd12; wdata0 = 8'hA5;
    push_cmd(1'b1, 6'd12, 8'hA5); push_ack(1'b0, 1'b0, 8'h00);
    tick();
    chk("t1_busy_access", 32'(busy), 32'd1);
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    tick();
    chk("t1_ack0", 32'(ack0), 32'd1);
    chk("t1_busy_ack", 32'(busy), 32'd0);
    req0 = 1'b0;
    tick();
    chk("t1_ack0_single", 32'(ack0), 32'd0);
    chk("t1_mem_en_idle", 32'(mem_en), 32'd0);

    // Single read from requester 1, RD_LAT=1: ack at t+3.
    req1 = 1'b1; wr1 = 1'b0; addr1 = 6'd23;
    push_cmd(1'b0, 6'd23, 8'h00); push_ack(1'b1, 1'b1, 8'h3C);
    tick();
    chk("t2_mem_wr", 32'(mem_wr), 32'd0);
    tick();
    chk("t2_ack1_early", 32'(ack1), 32'd0);
    tick();
    chk("t2_ack1", 32'(ack1), 32'd1);
    chk("t2_rdata", 32'(rdata), 32'h3C);
    req1 = 1'b0;
    tick();

    // Contention from reset: expected grant order 0,1,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 6'd14; wdata0 = 8'h5A;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 6'd48;
    for (int k = 0; k < 2; k++) begin
      push_cmd(1'b1, 6'd14, 8'h5A); push_ack(1'b0, 1'b0, 8'h00);
      push_cmd(1'b0, 6'd48, 8'h00); push_ack(1'b1, 1'b1, 8'h77);
    end
    n_ack = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ack0 || ack1) n_ack++;
      if (n_ack == 4) break;
    end
    chk("t3_ack_count", 32'(n_ack), 32'd4);
    req0 = 1'b0;
    // req1 still held in its ack cycle: must not be re-granted at that edge.
    push_cmd(1'b0, 6'd48, 8'h00); push_ack(1'b1, 1'b1, 8'h77);
    tick();
    chk("t3_no_regrant_en", 32'(mem_en), 32'd0);
    chk("t3_no_regrant_busy", 32'(busy), 32'd0);
    wait_ack(1'b1, 10);
    req1 = 1'b0;
    tick();

    // Reset in the middle of a read: no ack, all outputs cleared.
    req1 = 1'b1; wr1 = 1'b0; addr1 = 6'd56;
    push_cmd(1'b0, 6'd56, 8'h00);
    tick();
    tick();
    chk("t4_busy_rdwait", 32'(busy), 32'd1);
    rst = 1'b1; req1 = 1'b0;
    tick();
    chk("t4_mem_en", 32'(mem_en), 32'd0);
    chk("t4_mem_wr", 32'(mem_wr), 32'd0);
    chk("t4_mem_addr", 32'(mem_addr), 32'd0);
    chk("t4_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("t4_rdata", 32'(rdata), 32'd0);
    chk("t4_acks", 32'({ack0, ack1}), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("t4_no_ack1", 32'(ack1), 32'd0);
    req0 = 1'b1; wr0 = 1'b1; addr0 = 6'd33; wdata0 = 8'h11;
    push_cmd(1'b1, 6'd33, 8'h11); push_ack(1'b0, 1'b0, 8'h00);
    wait_ack(1'b0, 10);
    req0 = 1'b0;
    tick();

    // Request withdrawn and address changed after grant.
    req0 = 1'b1; wr0 = 1'b0; addr0 = 6'd23;
    push_cmd(1'b0, 6'd23, 8'h00); push_ack(1'b0, 1'b1, 8'h3C);
    tick();
    req0 = 1'b0; addr0 = 6'd5;
    tick();
    chk("t5_addr_hold", 32'(mem_addr), 32'd23);
    tick();
    chk("t5_ack0", 32'(ack0), 32'd1);
    chk("t5_addr_ack", 32'(mem_addr), 32'd23);
    tick();

    // A write leaves rdata alone; reading the written location returns it.
    req1 = 1'b1; wr1 = 1'b1; addr1 = 6'd40; wdata1 = 8'hC3;
    push_cmd(1'b1, 6'd40, 8'hC3); push_ack(1'b1, 1'b0, 8'h00);
    wait_ack(1'b1, 10);
    req1 = 1'b0;
    chk("t6_rdata_hold", 32'(rdata), 32'h3C);
    tick();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 6'd40;
    push_cmd(1'b0, 6'd40, 8'h00); push_ack(1'b0, 1'b1, 8'hC3);
    wait_ack(1'b0, 10);
    req0 = 1'b0;
    tick();
    tick();
    chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
